fir_filter_tdm: RTL

FIR_FILTER_TDM -- requirements
Module: fir_filter_tdm

---
 rtl/fir_filter_tdm.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fir_filter_tdm.sv
// fir_filter_tdm: time-multiplexed multi-channel FIR filter with a single
// multiply-accumulate unit and double-buffered (shadow/active) coefficients.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   din          signed input sample, in_chan selects its channel
//   in_valid     input handshake (in_ready is high only while idle)
//   in_ready
//   dout         signed filtered sample, out_chan is its channel
//   out_valid    output handshake (out_ready from the consumer)
//   out_ready
//   coeff_update writes new_coeff into shadow tap coeff_sel
//   coeff_sel
//   new_coeff
//   coeff_commit copies the shadow bank into the active bank (deferred
//                to the end of the current sample when not idle)
//   busy         high while a sample is being computed or presented
module fir_filter_tdm #(
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 16,
    parameter int TAPS      = 41,
    parameter int CHANNELS  = 2,
    parameter int OUT_SHIFT = 15,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int TAP_W    = $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [DATA_W-1:0]  din,
    input  logic [CH_W-1:0]           in_chan,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [DATA_W-1:0]  dout,
    output logic [CH_W-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      coeff_update,
    input  logic [TAP_W-1:0]          coeff_sel,
    input  logic signed [COEFF_W-1:0] new_coeff,
    input  logic                      coeff_commit,
    output logic                      busy
);

    localparam int PROD_W = DATA_W + COEFF_W;
    // TAP_W guard bits: TAPS full-scale products cannot overflow the sum.
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [ACC_W-1:0] RND_ADD =
        (OUT_SHIFT > 0) ? (ACC_W'(1) << RND_SH) : ACC_W'(0);
    localparam logic signed [DATA_W-1:0] DMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Clamp a wide accumulator value into the signed output range.
    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] smax;
        logic signed [ACC_W-1:0] smin;
        smax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        smin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > smax) begin
            sat_out = DMAX;
        end else if (v < smin) begin
            sat_out = DMIN;
        end else begin
            sat_out = v[DATA_W-1:0];
        end
    endfunction

    state_t                     state_r, state_nxt_s;
    logic signed [DATA_W-1:0]   dline_r [CHANNELS][TAPS];
    logic signed [COEFF_W-1:0]  shadow_r [TAPS];
    logic signed [COEFF_W-1:0]  shadow_nxt_s [TAPS];
    logic signed [COEFF_W-1:0]  active_r [TAPS];
    logic signed [ACC_W-1:0]    acc_r, acc_sum_s, rnd_s, shr_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic [TAP_W-1:0]           k_r;
    logic [CH_W-1:0]            chan_r, out_chan_r;
    logic signed [DATA_W-1:0]   dout_r;
    logic                       in_ready_r, out_valid_r, busy_r, pending_r;
    logic                       chan_ok_s, sel_ok_s, start_s, out_xfer_s, last_tap_s, copy_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign dout      = dout_r;
    assign out_chan  = out_chan_r;

    assign chan_ok_s  = int'(in_chan) < CHANNELS;
    assign sel_ok_s   = int'(coeff_sel) < TAPS;
    // Transfers with an out-of-range channel are accepted but start nothing.
    assign start_s    = in_valid && in_ready_r && (state_r == ST_IDLE) && chan_ok_s;
    assign out_xfer_s = out_valid_r && out_ready;
    assign last_tap_s = (state_r == ST_MAC) && (k_r == TAP_W'(TAPS - 1));

    // Next-state logic for the IDLE -> MAC -> OUT sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nxt_s = ST_MAC;
                else         state_nxt_s = ST_IDLE;
            end
            ST_MAC: begin
                if (last_tap_s) state_nxt_s = ST_OUT;
                else            state_nxt_s = ST_MAC;
            end
            ST_OUT: begin
                if (out_xfer_s) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // One tap per cycle; the final tap is folded into the rounded/saturated result.
    always_comb begin
        prod_s    = dline_r[chan_r][k_r] * active_r[k_r];
        acc_sum_s = acc_r + {{TAP_W{prod_s[PROD_W-1]}}, prod_s};
        rnd_s     = acc_sum_s + RND_ADD;
        shr_s     = rnd_s >>> OUT_SHIFT;
    end

    // Shadow bank next value, so a same-edge update is part of a commit copy.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (coeff_update && sel_ok_s) begin
            shadow_nxt_s[coeff_sel] = new_coeff;
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Copy now when idle; otherwise only on the OUT -> IDLE edge.
    always_comb begin
        copy_s = 1'b0;
        if (state_r == ST_IDLE) begin
            copy_s = coeff_commit;
        end else if ((state_r == ST_OUT) && out_xfer_s) begin
            copy_s = coeff_commit || pending_r;
        end else begin
            copy_s = 1'b0;
        end
    end

    // FSM state, handshake flags and the MAC datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            acc_r       <= '0;
            k_r         <= '0;
            chan_r      <= '0;
            dout_r      <= '0;
            out_chan_r  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int t = 0; t < TAPS; t++) begin
                    dline_r[c][t] <= '0;
                end
            end
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_OUT);
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (start_s) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (CH_W'(c) == in_chan) begin
                        dline_r[c][0] <= din;
                        for (int t = 1; t < TAPS; t++) begin
                            dline_r[c][t] <= dline_r[c][t-1];
                        end
                    end
                end
                chan_r <= in_chan;
                acc_r  <= '0;
                k_r    <= '0;
            end
            if (state_r == ST_MAC) begin
                acc_r <= acc_sum_s;
                k_r   <= k_r + TAP_W'(1);
                if (last_tap_s) begin
                    dout_r     <= sat_out(shr_s);
                    out_chan_r <= chan_r;
                end
            end
        end
    end

    // Coefficient banks and the deferred-commit flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r <= 1'b0;
            for (int t = 0; t < TAPS; t++) begin
                shadow_r[t] <= '0;
                active_r[t] <= '0;
            end
        end else begin
            shadow_r <= shadow_nxt_s;
            if (copy_s) begin
                active_r  <= shadow_nxt_s;
                pending_r <= 1'b0;
            end else if (coeff_commit && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end
        end
    end

endmodule
